// File: rtl/ms_pkg.sv
// Shared definitions for the millisecond countdown timer: default prescale
// ratio and the two-state controller encoding.
package ms_pkg;

    localparam int CYCLES_PER_MS_DEFAULT = 2500;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ms_state_t;

endpackage

// File: rtl/ms_countdown_if.sv
// Control and status bundle for ms_countdown; master drives requests,
// slave (the timer) returns the count and status flags.
interface ms_countdown_if #(
    parameter int WIDTH = 32
);
    // load is a single-cycle request that is always accepted on the edge it is
    // sampled (no ready); tick is a one-cycle pulse; expired is sticky until ack.
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             ack;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             busy;
    logic             expired;

    modport master (
        output en, load, load_val, auto_reload, ack,
        input  out, tick, busy, expired
    );

    modport slave (
        input  en, load, load_val, auto_reload, ack,
        output out, tick, busy, expired
    );

endinterface

// File: rtl/ms_prescaler.sv
// Divides the clock down to one wrap pulse per CYCLES_PER_MS enabled cycles.
// CYCLES_PER_MS must be at least 2 so the counter has a nonzero width.
module ms_prescaler
    import ms_pkg::*;
#(
    parameter int CYCLES_PER_MS = CYCLES_PER_MS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int            PW   = $clog2(CYCLES_PER_MS);
    localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_MS - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

    assign wrap = en && (cnt == LAST);

endmodule

// File: rtl/ms_countdown.sv
// Millisecond countdown timer with optional auto-reload and a sticky
// expired flag; prescaling lives in ms_prescaler.
module ms_countdown
    import ms_pkg::*;
#(
    parameter int CYCLES_PER_MS = CYCLES_PER_MS_DEFAULT,
    parameter int WIDTH         = 32
) (
    input  logic      clk,
    input  logic      rst,
    ms_countdown_if.slave bus,
    output ms_state_t state_dbg
);

    ms_state_t        state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] reload_reg, reload_n;
    logic             tick_q, tick_n;
    logic             expired_q, expired_n;
    logic             exp_set;
    logic             running, wrap, dec, reload_now, clr;

    assign running = (state == RUN);
    // RUN with a zero count only occurs after an auto-reload expiry.
    assign reload_now = running && bus.en && (count == '0);
    assign dec        = running && wrap && (count != '0);
    assign clr        = bus.load || !running || reload_now;

    ms_prescaler #(
        .CYCLES_PER_MS(CYCLES_PER_MS)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en && running),
        .clr  (clr),
        .wrap (wrap)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        tick_n   = 1'b0;
        exp_set  = 1'b0;
        if (bus.load) begin
            count_n  = bus.load_val;
            reload_n = bus.load_val;
            state_n  = (bus.load_val != '0) ? RUN : IDLE;
            exp_set  = (bus.load_val == '0);
        end else if (reload_now) begin
            count_n = reload_reg;
        end else if (dec) begin
            count_n = count - WIDTH'(1);
            tick_n  = 1'b1;
            if (count == WIDTH'(1)) begin
                exp_set = 1'b1;
                state_n = bus.auto_reload ? RUN : IDLE;
            end
        end
        // A new expiry outranks a simultaneous acknowledge.
        expired_n = exp_set ? 1'b1 : (bus.ack ? 1'b0 : expired_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tick_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            tick_q     <= tick_n;
            expired_q  <= expired_n;
        end
    end

    assign bus.out     = count;
    assign bus.tick    = tick_q;
    assign bus.busy    = running;
    assign bus.expired = expired_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_ms_countdown.sv
// Bench for ms_countdown: scoreboarded directed + random run at 4 cycles/ms,
// plus a millisecond-timing check of a default-parameter instance.
module tb_ms_countdown;
    import ms_pkg::*;

    localparam int C  = 4;
    localparam int W  = 8;
    localparam int EW = W + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ms_countdown_if #(.WIDTH(W)) bus ();
    ms_state_t state_dbg;

    ms_countdown #(.CYCLES_PER_MS(C), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    logic clk2 = 1'b0;
    logic rst2;
    always #200 clk2 = ~clk2;

    ms_countdown_if #(.WIDTH(32)) bus2 ();
    ms_state_t state_dbg2;

    ms_countdown dut2 (
        .clk       (clk2),
        .rst       (rst2),
        .bus       (bus2),
        .state_dbg (state_dbg2)
    );

    int total = 0;
    int bad   = 0;
    bit done2 = 1'b0;
    string phase_name = "reset";
    logic [EW-1:0] exp_q[$];

    // Reference: remaining ms, cycles elapsed within the current ms, running flag.
    int m_rem, m_reload, m_phase;
    bit m_run, m_exp, m_tick;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int lv,
                        input bit ar, input bit a);
        bit set_exp;
        @(negedge clk);
        rst = r; bus.en = e; bus.load = l; bus.load_val = W'(lv);
        bus.auto_reload = ar; bus.ack = a;
        set_exp = 1'b0;
        if (r) begin
            m_rem = 0; m_reload = 0; m_phase = 0;
            m_run = 1'b0; m_tick = 1'b0; m_exp = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (l) begin
                m_rem = lv; m_reload = lv; m_phase = 0;
                m_run = (lv != 0);
                set_exp = (lv == 0);
            end else if (m_run && e) begin
                if (m_rem == 0) begin
                    m_rem = m_reload;
                    m_phase = 0;
                end else begin
                    m_phase++;
                    if (m_phase == C) begin
                        m_phase = 0;
                        m_rem--;
                        m_tick = 1'b1;
                        if (m_rem == 0) begin
                            set_exp = 1'b1;
                            m_run = ar;
                        end
                    end
                end
            end
            m_exp = set_exp || (m_exp && !a);
        end
        exp_q.push_back({W'(m_rem), m_tick, m_run, m_exp, m_run});
    endtask

    task automatic idle(input int n, input bit e, input bit ar);
        repeat (n) step(1'b0, e, 1'b0, 0, ar, 1'b0);
    endtask

    // Monitor: compares DUT outputs just after each edge against the queue head.
    initial begin
        logic [EW-1:0] e_v, a_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e_v = exp_q.pop_front();
                a_v = {bus.out, bus.tick, bus.busy, bus.expired, logic'(state_dbg)};
                total++;
                if (a_v !== e_v) begin
                    bad++;
                    $display("FAIL sb[%s] t=%0t actual out=%0d tick=%0b busy=%0b exp=%0b st=%0b required out=%0d tick=%0b busy=%0b exp=%0b st=%0b",
                             phase_name, $time, a_v[EW-1:4], a_v[3], a_v[2], a_v[1], a_v[0],
                             e_v[EW-1:4], e_v[3], e_v[2], e_v[1], e_v[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.auto_reload = 1'b0; bus.ack = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        phase_name = "count3";
        step(1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        idle(16, 1'b1, 1'b0);

        phase_name = "autoreload";
        step(1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        idle(10, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        idle(10, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);

        phase_name = "freeze";
        step(1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b0);
        idle(10, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);

        phase_name = "load_on_wrap";
        step(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);

        phase_name = "rst_mid";
        step(1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        idle(5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b1);
        idle(6, 1'b1, 1'b0);

        phase_name = "random";
        repeat (3000) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 29) == 0, int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        for (int i = 0; i < 6000 && !done2; i++) @(negedge clk2);
        check("ms_bench_done", int'(done2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Default-parameter instance: real millisecond spacing at a 400 ns clock.
    initial begin
        int c, t1, t2, te;
        t1 = -1; t2 = -1; te = -1;
        rst2 = 1'b1; bus2.en = 1'b1; bus2.load = 1'b0; bus2.load_val = '0;
        bus2.auto_reload = 1'b0; bus2.ack = 1'b0;
        repeat (2) @(negedge clk2);
        rst2 = 1'b0;
        check("ms_reset_out", int'(bus2.out), 0);
        check("ms_reset_busy", int'(bus2.busy), 0);
        bus2.load = 1'b1; bus2.load_val = 32'd2;
        @(posedge clk2);
        #1;
        bus2.load = 1'b0;
        check("ms_load_out", int'(bus2.out), 2);
        check("ms_load_busy", int'(bus2.busy), 1);
        c = 1;
        while (c < 5010) begin
            if (bus2.tick) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
            if (bus2.expired && te < 0) te = c;
            @(posedge clk2);
            #1;
            c++;
        end
        check("ms_first_tick", t1, 2501);
        check("ms_second_tick", t2, 5001);
        check("ms_expired_cycle", te, 5001);
        check("ms_final_out", int'(bus2.out), 0);
        check("ms_final_busy", int'(bus2.busy), 0);
        check("ms_final_state", int'(state_dbg2), int'(IDLE));
        done2 = 1'b1;
    end

endmodule

// File: doc/ms_countdown.md
MS_COUNTDOWN -- requirements
Module: ms_countdown

Interface
REQ-001 Parameter CYCLES_PER_MS, default 2500, clock cycles per millisecond (2.5 MHz clock).
REQ-002 Parameter WIDTH, default 32, width of the millisecond count.
REQ-003 The design SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; low freezes prescaler and count.
REQ-007 load  input  1  single-cycle request; captures load_val.
REQ-008 load_val  input  WIDTH  starting milliseconds to count down from.
REQ-009 auto_reload  input  1  when high at expiry, restart from the last loaded value.
REQ-010 ack  input  1  clears expired.
REQ-011 out  output  WIDTH  remaining milliseconds.
REQ-012 tick  output  1  registered one-cycle pulse on every count decrement.
REQ-013 busy  output  1  high while in RUN.
REQ-014 expired  output  1  sticky flag, set when out reaches 0 by counting.

Function
REQ-015 State machine SHALL have two states, IDLE and RUN; busy is high exactly in RUN.
REQ-016 load in any state SHALL, at the next edge, set out=load_val, reload_reg=load_val, prescaler=0.
REQ-017 On that edge, state SHALL go to RUN if load_val != 0.
REQ-018 A load with load_val = 0 SHALL go to IDLE, set expired and emit no tick.
REQ-019 In RUN with en=1, the prescaler SHALL count 0..CYCLES_PER_MS-1 and then wrap to 0.
REQ-020 At the wrap, out SHALL decrement by 1 and tick SHALL be high for that one following cycle.
REQ-021 After a load in cycle k with en held high, the first decrement SHALL be visible at cycle k+1+CYCLES_PER_MS.
REQ-022 With en=0, prescaler, out and state SHALL hold, and tick SHALL be 0.
REQ-023 When a decrement takes out from 1 to 0, expired SHALL be set on the same edge.
REQ-024 In that case, if auto_reload=1, out SHALL take reload_reg on the following edge, prescaler=0, state stays RUN.
REQ-025 Otherwise (auto_reload=0), state SHALL go to IDLE and out SHALL hold 0.
REQ-026 In IDLE, the prescaler SHALL hold 0 and out SHALL hold its value.
REQ-027 ack SHALL clear expired at the next edge.
REQ-028 If ack coincides with an expiry event, set SHALL win and expired stays 1.
REQ-029 If load coincides with a prescaler wrap or an expiry, load SHALL win: no decrement, no tick, no expired set.
REQ-030 If load coincides with a pending auto-reload, load SHALL win over the reload.
REQ-031 Arithmetic SHALL be unsigned WIDTH-bit; out SHALL never wrap below 0.
REQ-032 The prescaler SHALL be $clog2(CYCLES_PER_MS) bits wide.

Reset
REQ-033 rst=1 at an edge SHALL force state=IDLE, out=0, reload_reg=0, prescaler=0, tick=0, expired=0, busy=0.
REQ-034 rst SHALL have priority over load, ack and en, including mid-count.
REQ-035 After rst deasserts, the block SHALL stay in IDLE until a load.

Structure
REQ-036 Shared package ms_pkg SHALL hold the CYCLES_PER_MS default (2500) and the IDLE/RUN state encoding.
REQ-037 Prescaler SHALL be a sub-module ms_prescaler (inputs clk, rst, en, clr; output wrap pulse); the rest is in ms_countdown.

Verification
REQ-038 CYCLES_PER_MS=4, load 3 at cycle 0, en=1 -> out 3,2,1,0 at cycles 5,9,13; expired=1 and busy=0 from cycle 13.
REQ-039 CYCLES_PER_MS=4, auto_reload=1, load 2 -> expired at cycle 9, out=2 at cycle 10, next tick at cycle 14; ack at cycle 11 clears expired.
REQ-040 en low for 10 cycles mid-count -> out and tick frozen; the expiry cycle shifts by exactly 10.
REQ-041 Load 5 on a wrap cycle -> out=5, no tick, prescaler restarts; load 0 -> expired=1, busy=0, no tick.
REQ-042 rst asserted mid-count with expired=1 -> all outputs 0 the next cycle; load ignored during rst.
REQ-043 Default CYCLES_PER_MS=2500, 400 ns clock period, load 2 -> tick every 1 ms; expired at 2 ms + 1 cycle after the load.
